// File: rtl/dut_result_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : dut_result_checker_if
// Description : Result-stream and mismatch-log handshake bundle between a
//               stimulus/result source (master) and dut_result_checker (slave).
//   res_valid/res_ready       : result beat handshake
//   res_data/exp_data/exp_mask: beat payload (result, expected, compare mask)
//   log_valid/log_ready       : mismatch log head handshake
//   log_idx/log_diff          : log head payload (beat index, masked diff)
// Revision    : 1.0 - initial release
// ============================================================================
interface dut_result_checker_if #(
   parameter int OUT_W = 30,
   parameter int IDX_W = 16
);
   logic             res_valid;
   logic [OUT_W-1:0] res_data;
   logic [OUT_W-1:0] exp_data;
   logic [OUT_W-1:0] exp_mask;
   logic             res_ready;
   logic             log_valid;
   logic [IDX_W-1:0] log_idx;
   logic [OUT_W-1:0] log_diff;
   logic             log_ready;

   modport master (
      output res_valid, res_data, exp_data, exp_mask, log_ready,
      input  res_ready, log_valid, log_idx, log_diff
   );

   modport slave (
      input  res_valid, res_data, exp_data, exp_mask, log_ready,
      output res_ready, log_valid, log_idx, log_diff
   );
endinterface
`default_nettype wire

// File: rtl/dut_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : dut_result_checker
// Description : Clocked checker for the 30-bit DUT result stream. Compares
//               each beat against an expected value under a per-bit mask,
//               counts mismatching beats (saturating) and logs the index and
//               masked difference of failing beats into a small FIFO.
// Ports       : clk, rst (async, active-high)
//               start_i, num_vec_i : run start pulse and run length
//               bus (slave)        : result beats in, mismatch log out
//               busy_o, done_o, pass_o, err_count_o : run status
//               stop_idx_o         : first failing beat (optional feature)
// Options     : DUT_CHK_STOP_ON_ERR_EN - first mismatch ends the run early
//               and adds the stop_idx_o output.
// Revision    : 1.0 - initial release
// ============================================================================
module dut_result_checker #(
   parameter int OUT_W     = 30,
   parameter int IDX_W     = 16,
   parameter int LOG_DEPTH = 4
) (
   input  wire              clk,
   input  wire              rst,
   input  wire              start_i,
   input  wire  [IDX_W-1:0] num_vec_i,
   dut_result_checker_if.slave bus,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [IDX_W-1:0] err_count_o
`ifdef DUT_CHK_STOP_ON_ERR_EN
   ,
   output logic [IDX_W-1:0] stop_idx_o
`endif
);

   localparam int PTR_W = $clog2(LOG_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] num_vec_q;
   logic [IDX_W-1:0] idx_q;
   logic             s1_valid_q;
   logic [OUT_W-1:0] s1_diff_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic [IDX_W-1:0] err_q;
   logic             drain_q;
   logic             done_q, pass_q;
   logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
   logic [IDX_W-1:0] mem_idx  [LOG_DEPTH];
   logic [OUT_W-1:0] mem_diff [LOG_DEPTH];

   logic w_start, w_accept, w_last, w_mismatch, w_stop;
   logic w_empty, w_full, w_push, w_pop;

   // start is honoured only when no run is in flight
   assign w_start    = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign w_accept   = bus.res_valid && bus.res_ready;
   assign w_last     = (idx_q == (num_vec_q - IDX_W'(1)));
   assign w_mismatch = s1_valid_q && (s1_diff_q != '0);

`ifdef DUT_CHK_STOP_ON_ERR_EN
   // A stage-2 mismatch in RUN closes the input in the same cycle
   assign w_stop = (state_q == S_RUN) && w_mismatch;
`else
   assign w_stop = 1'b0;
`endif

   // Log FIFO: pointers carry one extra wrap bit to tell full from empty
   assign w_empty = (wr_ptr_q == rd_ptr_q);
   assign w_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign w_pop   = !w_empty && bus.log_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still takes it
   assign w_push  = w_mismatch && (!w_full || w_pop);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start_i) state_d = (num_vec_i == '0) ? S_DONE : S_RUN;
         S_RUN:          if (w_stop || (w_accept && w_last)) state_d = S_DRAIN;
         S_DRAIN:        if (drain_q) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.res_ready = (state_q == S_RUN) && !w_stop;
      busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN);
   end

   // ---------------- Pipeline, counters and status ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_vec_q  <= '0;
         idx_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_diff_q  <= '0;
         s1_idx_q   <= '0;
         err_q      <= '0;
         drain_q    <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         drain_q <= (state_q == S_DRAIN) ? !drain_q : 1'b0;
         if (w_start) begin
            num_vec_q  <= num_vec_i;
            idx_q      <= '0;
            s1_valid_q <= 1'b0;
            err_q      <= '0;
            // A zero-length run has nothing to check and passes at once
            done_q     <= (num_vec_i == '0);
            pass_q     <= (num_vec_i == '0);
         end else begin
            s1_valid_q <= w_accept;
            if (w_accept) begin
               s1_diff_q <= (bus.res_data ^ bus.exp_data) & bus.exp_mask;
               s1_idx_q  <= idx_q;
               idx_q     <= idx_q + IDX_W'(1);
            end
            if (w_mismatch && !(&err_q)) err_q <= err_q + IDX_W'(1);
            // Last stage-2 update lands on the first DRAIN edge, so err_q is final here
            if ((state_q == S_DRAIN) && drain_q) begin
               done_q <= 1'b1;
               pass_q <= (err_q == '0);
            end
         end
      end
   end

   // ---------------- Log FIFO pointers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (w_start) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible between push and pop
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_idx[wr_ptr_q[PTR_W-1:0]]  <= s1_idx_q;
         mem_diff[wr_ptr_q[PTR_W-1:0]] <= s1_diff_q;
      end
   end

   assign bus.log_valid = !w_empty;
   assign bus.log_idx   = w_empty ? '0 : mem_idx[rd_ptr_q[PTR_W-1:0]];
   assign bus.log_diff  = w_empty ? '0 : mem_diff[rd_ptr_q[PTR_W-1:0]];

   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign err_count_o = err_q;

`ifdef DUT_CHK_STOP_ON_ERR_EN
   logic [IDX_W-1:0] stop_idx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          stop_idx_q <= '0;
      else if (w_start) stop_idx_q <= '0;
      else if (w_stop)  stop_idx_q <= s1_idx_q;
   end

   assign stop_idx_o = stop_idx_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dut_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_dut_result_checker
// Description : Self-checking bench for dut_result_checker: vector table,
//               randomized runs against a queue-based reference model, and
//               hand-written reset / zero-length sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dut_result_checker;
   localparam int OUT_W     = 30;
   localparam int IDX_W     = 16;
   localparam int LOG_DEPTH = 4;
   localparam int MAXB      = 32;
   localparam logic [OUT_W-1:0] ALL1  = {OUT_W{1'b1}};
   localparam logic [OUT_W-1:0] FLIP  = 30'h2000_0008;
   localparam logic [OUT_W-1:0] MMASK = 30'h1FFF_FFF7;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [IDX_W-1:0] num_vec;
   logic             busy, done, pass;
   logic [IDX_W-1:0] err_count;
`ifdef DUT_CHK_STOP_ON_ERR_EN
   logic [IDX_W-1:0] stop_idx;
`endif

   dut_result_checker_if #(.OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

   dut_result_checker #(.OUT_W(OUT_W), .IDX_W(IDX_W), .LOG_DEPTH(LOG_DEPTH)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .num_vec_i   (num_vec),
      .bus         (bus),
      .busy_o      (busy),
      .done_o      (done),
      .pass_o      (pass),
      .err_count_o (err_count)
`ifdef DUT_CHK_STOP_ON_ERR_EN
      ,
      .stop_idx_o  (stop_idx)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [OUT_W-1:0] v_res [MAXB];
   logic [OUT_W-1:0] v_exp [MAXB];
   logic [OUT_W-1:0] v_msk [MAXB];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; num_vec = '0;
      bus.res_valid = 1'b0; bus.res_data = '0; bus.exp_data = '0;
      bus.exp_mask = '0; bus.log_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Runs one checker pass over v_*[0..n-1] and checks it against the model.
   task automatic run_check(input int n, input bit mid_start, input bit gaps,
                            input bit chk_timing, output int acc,
                            output logic [IDX_W-1:0] got_err, output logic got_pass);
      int exp_acc, exp_err, first_bad, obs, ready_cnt;
      int q_idx[$];
      logic [OUT_W-1:0] q_diff[$];
      logic [OUT_W-1:0] d;
      bit gap;
      // Reference model: count failing beats, log the first LOG_DEPTH of them
      exp_acc = n; exp_err = 0; first_bad = -1;
      for (int k = 0; k < n; k++) begin
         d = (v_res[k] ^ v_exp[k]) & v_msk[k];
         if (d != '0) begin
            if (exp_err == 0) first_bad = k;
            exp_err++;
            if (q_idx.size() < LOG_DEPTH) begin
               q_idx.push_back(k);
               q_diff.push_back(d);
            end
`ifdef DUT_CHK_STOP_ON_ERR_EN
            exp_acc = k + 1;
            break;
`endif
         end
      end

      @(negedge clk);
      num_vec = IDX_W'(n); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_in_run", busy, 1);
      acc = 0; obs = 0; ready_cnt = 0;
      while (obs < 400) begin
         if (done) break;
         if (mid_start && obs == 1) begin num_vec = '0; start = 1'b1; end
         else start = 1'b0;
         gap = gaps && ($urandom_range(0, 3) == 0);
         if (acc < n && !gap) begin
            bus.res_valid = 1'b1;
            bus.res_data = v_res[acc]; bus.exp_data = v_exp[acc]; bus.exp_mask = v_msk[acc];
         end else begin
            bus.res_valid = 1'b0;
         end
         if (bus.res_ready) ready_cnt++;
         if (bus.res_ready && bus.res_valid) acc++;
         @(negedge clk);
         obs++;
      end
      start = 1'b0; bus.res_valid = 1'b0;
      if (obs >= 400) check("done_timeout", 0, 1);
      if (chk_timing) begin
         check("done_latency", obs, 6);
         check("ready_cycles", ready_cnt, n);
      end
      check("accepted_beats", acc, exp_acc);
      check("done", done, 1);
      check("busy_after", busy, 0);
      check("pass", pass, (exp_err == 0));
      check("err_count", err_count, exp_err);
`ifdef DUT_CHK_STOP_ON_ERR_EN
      if (first_bad >= 0) check("stop_idx", stop_idx, first_bad);
`endif
      got_err = err_count; got_pass = pass;
      for (int i = 0; i < q_idx.size(); i++) begin
         check("log_valid", bus.log_valid, 1);
         check("log_idx", bus.log_idx, q_idx[i]);
         check("log_diff", bus.log_diff, q_diff[i]);
         bus.log_ready = 1'b1;
         @(negedge clk);
         bus.log_ready = 1'b0;
      end
      check("log_empty", bus.log_valid, 0);
      check("done_held", done, 1);
   endtask

   typedef struct {
      int          n;
      logic [15:0] bad;
      bit          use_mask;
      bit          mid_start;
      bit          timing;
      int          exp_err;
      bit          exp_pass;
   } vec_t;

   vec_t tbl [6];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int acc;
      logic [IDX_W-1:0] gerr;
      logic gpass;
      logic [OUT_W-1:0] base;

      tbl[0] = '{4, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b1};  // clean run with latency check
      tbl[1] = '{3, 16'h0004, 1'b1, 1'b0, 1'b0, 0, 1'b1};  // mismatch hidden by mask
      tbl[2] = '{3, 16'h0004, 1'b0, 1'b0, 1'b0, 1, 1'b0};  // same mismatch, unmasked
      tbl[3] = '{8, 16'h00FF, 1'b0, 1'b0, 1'b0, 8, 1'b0};  // log overflow
      tbl[4] = '{6, 16'h0012, 1'b0, 1'b1, 1'b0, 2, 1'b0};  // start pulsed mid-run
      tbl[5] = '{1, 16'h0001, 1'b0, 1'b0, 1'b0, 1, 1'b0};  // single failing beat

      do_reset();
      check("rst_res_ready", bus.res_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err_count", err_count, 0);
      check("rst_log_valid", bus.log_valid, 0);
      check("rst_log_idx", bus.log_idx, 0);
      check("rst_log_diff", bus.log_diff, 0);

      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < tbl[t].n; k++) begin
            base = OUT_W'($urandom);
            v_exp[k] = base;
            v_res[k] = tbl[t].bad[k] ? (base ^ FLIP) : base;
            v_msk[k] = tbl[t].use_mask ? MMASK : ALL1;
         end
         run_check(tbl[t].n, tbl[t].mid_start, 1'b0, tbl[t].timing, acc, gerr, gpass);
`ifndef DUT_CHK_STOP_ON_ERR_EN
         check("tbl_err", gerr, tbl[t].exp_err);
         check("tbl_pass", gpass, tbl[t].exp_pass);
`endif
      end

      // Zero-length run right after a failing run: status must be cleared
      @(negedge clk);
      num_vec = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("zero_done", done, 1);
      check("zero_pass", pass, 1);
      check("zero_err", err_count, 0);
      check("zero_busy", busy, 0);

      // Async reset between edges while beat 3 of 6 is on the bus
      for (int k = 0; k < 6; k++) begin
         v_exp[k] = OUT_W'($urandom);
         v_res[k] = (k == 1) ? ~v_exp[k] : v_exp[k];
         v_msk[k] = ALL1;
      end
      @(negedge clk);
      num_vec = 16'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.res_valid = 1'b1;
         bus.res_data = v_res[k]; bus.exp_data = v_exp[k]; bus.exp_mask = v_msk[k];
         if (k < 3) @(negedge clk);
      end
      check("pre_rst_err", err_count, 1);
      check("pre_rst_log", bus.log_valid, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_res_ready", bus.res_ready, 0);
      check("arst_busy", busy, 0);
      check("arst_err", err_count, 0);
      check("arst_log_valid", bus.log_valid, 0);
      check("arst_log_idx", bus.log_idx, 0);
      check("arst_done", done, 0);
      @(negedge clk);
      rst = 1'b0; bus.res_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         v_exp[k] = OUT_W'($urandom); v_res[k] = v_exp[k]; v_msk[k] = ALL1;
      end
      run_check(2, 1'b0, 1'b0, 1'b0, acc, gerr, gpass);
      check("post_rst_pass", gpass, 1);

`ifdef DUT_CHK_STOP_ON_ERR_EN
      // Stop on first error: mismatch at beat 1 of 6
      for (int k = 0; k < 6; k++) begin
         v_exp[k] = OUT_W'($urandom);
         v_res[k] = (k == 1) ? (v_exp[k] ^ FLIP) : v_exp[k];
         v_msk[k] = ALL1;
      end
      run_check(6, 1'b0, 1'b0, 1'b0, acc, gerr, gpass);
      check("stop_accept_le3", (acc <= 3), 1);
      check("stop_idx_final", stop_idx, 1);
      check("stop_pass", gpass, 0);
`endif

      // Randomized runs against the reference model
      for (int r = 0; r < 12; r++) begin
         int n;
         n = $urandom_range(1, 12);
         for (int k = 0; k < n; k++) begin
            v_exp[k] = OUT_W'($urandom);
            v_msk[k] = ($urandom_range(0, 1) == 0) ? ALL1 : OUT_W'($urandom);
            v_res[k] = ($urandom_range(0, 2) == 0) ? (v_exp[k] ^ OUT_W'($urandom)) : v_exp[k];
         end
         run_check(n, 1'b0, 1'b1, 1'b0, acc, gerr, gpass);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dut_result_checker.md
Name: dut_result_checker

Overview:
Downstream stage of the combinational 50-in/30-out DUT. Consumes the DUT's 30-bit result stream beat by beat and compares each beat, under a per-bit mask, against an expected value supplied alongside it. Counts mismatches and logs the index and difference pattern of failing beats into a small FIFO. Reports pass/fail at end of run. Replaces the file-dump-and-diff flow with an in-sim, clocked checker.

Parameters:
OUT_W, 30, result/expected/mask width (matches DUT out[29:0])
IDX_W, 16, vector index and counter width
LOG_DEPTH, 4, mismatch log FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle run start pulse
num_vec  in  IDX_W  beats in run, sampled on start
res_valid  in  1  result beat valid
res_data  in  OUT_W  DUT result
exp_data  in  OUT_W  expected result, same beat
exp_mask  in  OUT_W  1 = compare bit, 0 = don't-care
res_ready  out  1  checker accepts beat
busy  out  1  run in progress (RUN or DRAIN)
done  out  1  run complete, held until next start
pass  out  1  valid when done; 1 iff err_count==0
err_count  out  IDX_W  mismatching beats this run, saturating
log_valid  out  1  log FIFO non-empty
log_idx  out  IDX_W  index of logged failing beat
log_diff  out  OUT_W  (res^exp)&mask of logged beat
log_ready  in  1  pop log head

Behaviour:
- Reset (async, rst=1): state IDLE; res_ready=0, busy=0, done=0, pass=0, err_count=0, log FIFO empty (log_valid=0, log_idx=0, log_diff=0), internal index=0.
- FSM IDLE/RUN/DRAIN/DONE.
- IDLE or DONE + start: clear err_count, index, log FIFO, done, pass. num_vec!=0 -> RUN; num_vec==0 -> DONE next cycle, pass=1.
- start while in RUN or DRAIN: ignored.
- RUN: res_ready=1 combinationally; beat accepted when res_valid&res_ready. No back-pressure from log FIFO.
- Stage 1 (accept cycle N): register diff=(res_data^exp_data)&exp_mask and the beat index; index increments.
- Stage 2 (cycle N+1): if diff!=0, err_count+=1, saturating at all-ones. If FIFO not full, push {index,diff}; if full, entry dropped and err_count still increments. err_count is visible at N+2.
- Accepting beat index num_vec-1 -> DRAIN, res_ready=0.
- DRAIN: 2 cycles while the pipeline empties -> DONE.
- DONE: done=1 and pass=(err_count==0) registered on entry, held until next start. Both are 0 outside DONE.
- Log FIFO: log_valid/log_idx/log_diff show the head; pop on log_valid&log_ready.
  - Simultaneous push and pop when full: allowed, no drop.
  - Pointers wrap modulo LOG_DEPTH.
  - Popping is allowed in any state.
- res_valid outside RUN: ignored, no effect.
- rst mid-run: immediate return to reset values, including FIFO contents.

Optional Feature:
DUT_CHK_STOP_ON_ERR_EN
- Defined: the first mismatch detected in stage 2 forces RUN -> DRAIN. res_ready drops in that same cycle, and no further beats are accepted. A beat already in stage 1 still completes and is counted/logged. done/pass follow as normal (pass=0). Adds output stop_idx[IDX_W-1:0] = index of first failing beat, reset 0.
- Undefined: the run always consumes num_vec beats; stop_idx port absent.

Test Plan:
- Clean run: num_vec=4, res_data==exp_data, exp_mask=all-ones, res_valid held high -> res_ready high 4 cycles; done=1 at start+1+4+2 cycles; pass=1, err_count=0, log_valid=0.
- Masked mismatch: res=30'h2000_0008, exp=30'h0000_0000 on beat 2 of 3. With mask=30'h1FFF_FFF7 -> pass=1. With mask=all-ones -> err_count=1, log_idx=2, log_diff=30'h2000_0008.
- Log overflow: num_vec=8, all beats mismatch, log_ready=0 -> err_count=8; log holds idx 0..3 only. Popping 4 times yields 0,1,2,3, then log_valid=0.
- Zero-length and ignored start: start with num_vec=0 -> done next cycle, pass=1. start pulsed mid-RUN -> no effect on index or err_count.
- Async reset mid-run: rst asserted between clock edges during beat 3 of 6 -> outputs reach reset values before the next edge; a subsequent run of 2 clean beats passes.
- DUT_CHK_STOP_ON_ERR_EN: 6 beats with mismatch at idx 1 -> at most beats 0..2 accepted; stop_idx=1, pass=0, done asserted.
